// File: rtl/alu_mdu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_mdu
//  Purpose  : Iterative RV32M/RV64M multiply/divide unit. 1-bit-per-cycle
//             shift-add multiplier and restoring divider behind a
//             valid/ready handshake. Divide-by-zero and signed overflow
//             bypass the iteration and complete immediately.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             flush               - kill any in-flight operation
//             in_valid/in_ready   - request handshake (ready only in IDLE)
//             mdu_op, op_A, op_B  - funct3 op code and operands
//             rd_tag              - destination tag, returned as out_tag
//             out_valid/out_ready - result handshake
//             mdu_o, out_tag      - result and its tag
//             busy                - unit not idle
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      mdu_op,
    input  logic [XLEN-1:0] op_A,
    input  logic [XLEN-1:0] op_B,
    input  logic [4:0]      rd_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] mdu_o,
    output logic [4:0]      out_tag,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0]  C_MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  C_ALL_ONES = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;
    logic [4:0]          tag_q;
    logic [2*XLEN-1:0]   acc_q;     // product, or {remainder, quotient}
    logic [XLEN-1:0]     b_q;       // multiplicand or divisor magnitude
    logic                neg_q;     // negate the selected result in FIX
    logic                out_valid_q;
    logic [XLEN-1:0]     mdu_q;
    logic [4:0]          out_tag_q;

    // Operand conditioning at accept
    logic                w_sgn_a, w_sgn_b, w_neg_d;
    logic [XLEN-1:0]     w_abs_a, w_abs_b;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;

    always_comb begin
        w_sgn_a = 1'b0;
        w_sgn_b = 1'b0;
        case (mdu_op)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                w_sgn_a = op_A[XLEN-1];
                w_sgn_b = op_B[XLEN-1];
            end
            3'd2:    w_sgn_a = op_A[XLEN-1];   // MULHSU: B is unsigned
            default: ;
        endcase
        w_abs_a = w_sgn_a ? (~op_A + 1'b1) : op_A;
        w_abs_b = w_sgn_b ? (~op_B + 1'b1) : op_B;
        // Remainder follows the dividend; everything else follows A^B.
        w_neg_d = (mdu_op == 3'd6) ? w_sgn_a : (w_sgn_a ^ w_sgn_b);

        w_special     = 1'b0;
        w_special_res = '0;
        if (mdu_op[2] && (op_B == '0)) begin
            w_special     = 1'b1;
            w_special_res = mdu_op[1] ? op_A : C_ALL_ONES;
        end else if (((mdu_op == 3'd4) || (mdu_op == 3'd6)) &&
                     (op_A == C_MIN_INT) && (op_B == C_ALL_ONES)) begin
            w_special     = 1'b1;
            w_special_res = mdu_op[1] ? '0 : C_MIN_INT;
        end
    end

    // One iteration of multiply / divide
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_rem;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_div_diff;
    logic [2*XLEN-1:0]   w_div_next;

    always_comb begin
        w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
        w_mul_next = acc_q[0] ? {w_mul_sum, acc_q[XLEN-1:1]}
                              : {1'b0, acc_q[2*XLEN-1:1]};
        // Shifted partial remainder is XLEN+1 bits; "no borrow" on the
        // trial subtract is the same as rem >= divisor. When it succeeds
        // the difference is below the divisor, so XLEN bits suffice.
        w_div_rem  = acc_q[2*XLEN-1:XLEN-1];
        w_div_ge   = (w_div_rem >= {1'b0, b_q});
        w_div_diff = w_div_rem[XLEN-1:0] - b_q;
        w_div_next = w_div_ge ? {w_div_diff, acc_q[XLEN-2:0], 1'b1}
                              : {acc_q[2*XLEN-2:0], 1'b0};
    end

    // Sign fix-up and field select
    logic [XLEN-1:0]     w_div_val, w_div_res, w_mul_res, w_fix_res;
    logic [2*XLEN-1:0]   w_prod;

    always_comb begin
        w_div_val = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        w_div_res = neg_q ? (~w_div_val + 1'b1) : w_div_val;
        w_prod    = neg_q ? (~acc_q + 1'b1) : acc_q;
        w_mul_res = (op_q[1:0] == 2'd0) ? w_prod[XLEN-1:0]
                                        : w_prod[2*XLEN-1:XLEN];
        w_fix_res = op_q[2] ? w_div_res : w_mul_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            mdu_q       <= '0;
            out_tag_q   <= '0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q  <= mdu_op;
                        tag_q <= rd_tag;
                        neg_q <= w_neg_d;
                        if (w_special) begin
                            mdu_q     <= w_special_res;
                            out_tag_q <= rd_tag;
                            state_q   <= S_DONE;
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, w_abs_a};
                            b_q     <= w_abs_b;
                            cnt_q   <= C_CNT_INIT;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= op_q[2] ? w_div_next : w_mul_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == C_CNT_ONE) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    mdu_q     <= w_fix_res;
                    out_tag_q <= tag_q;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    // out_valid rises one cycle after entering DONE.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign mdu_o     = mdu_q;
    assign out_tag   = out_tag_q;

endmodule
`default_nettype wire
